// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch sequencer states and the
// field widths used by the fetch unit, the control unit and the program ROM.
package cpu_pkg;

  localparam int ROM_ADDR_W = 8;
  localparam int INSTR_W    = 16;
  localparam int OPCODE_W   = 4;
  localparam int OPERAND_W  = INSTR_W - OPCODE_W;

  // Opcode encodings shared with the control unit's decoder.
  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_MOV  = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_NOT  = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_LT   = 4'b1010;
  localparam logic [OPCODE_W-1:0] OP_EQ   = 4'b1011;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'b1100;
  localparam logic [OPCODE_W-1:0] OP_HALT = 4'b1111;

  // Fetch sequencer states, kept as plain constants for legacy tooling.
  typedef logic [2:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE   = 3'd0;
  localparam fetch_state_t ST_FETCH  = 3'd1;
  localparam fetch_state_t ST_LATCH  = 3'd2;
  localparam fetch_state_t ST_ISSUE  = 3'd3;
  localparam fetch_state_t ST_HALTED = 3'd4;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register for the fetch sequencer: synchronous load has
// priority over increment; asynchronous reset returns it to RESET_PC.
module fetch_pc #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              incr,
  output logic [ADDR_W-1:0] pc
);

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (incr) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: drives the program ROM, consumes NOP/HALT (and
// JMP when FETCH_JUMP_EN is defined) and issues all other opcodes downstream.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stall,
  output logic [ADDR_W-1:0]          rom_address,
  output logic                       rom_read_enable,
  input  logic [DATA_W-1:0]          rom_data,
  output logic [OPCODE_W-1:0]        opcode,
  output logic [DATA_W-OPCODE_W-1:0] operand,
  output logic                       instr_valid,
  output logic                       halted,
  output logic [ADDR_W-1:0]          pc
);

  localparam int OPND_W = DATA_W - OPCODE_W;

  fetch_state_t state, state_nxt;

  logic [OPCODE_W-1:0] word_op;
  logic [OPND_W-1:0]   word_opnd;
  logic                pc_load;
  logic                pc_incr;
  logic [ADDR_W-1:0]   pc_load_value;

  assign word_op   = rom_data[DATA_W-1 -: OPCODE_W];
  assign word_opnd = rom_data[OPND_W-1:0];

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_nxt     = state;
    pc_load       = 1'b0;
    pc_incr       = 1'b0;
    pc_load_value = RESET_PC;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_nxt = ST_FETCH;
          pc_load   = 1'b1;
        end
      end
      ST_FETCH: state_nxt = ST_LATCH;
      ST_LATCH: begin
        // The word on rom_data is the one requested during FETCH.
        pc_incr = 1'b1;
        if (word_op == OP_HALT) begin
          state_nxt = ST_HALTED;
`ifdef FETCH_JUMP_EN
        end else if (word_op == OP_JMP) begin
          state_nxt     = ST_FETCH;
          pc_load       = 1'b1;
          pc_load_value = word_opnd[ADDR_W-1:0];
`endif
        end else if (word_op == OP_NOP) begin
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!stall) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      opcode  <= '0;
      operand <= '0;
    end else begin
      state <= state_nxt;
      // Issued fields only change when a new instruction enters ISSUE.
      if (state == ST_LATCH && state_nxt == ST_ISSUE) begin
        opcode  <= word_op;
        operand <= word_opnd;
      end
    end
  end

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_fetch_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pc_load),
    .load_value (pc_load_value),
    .incr       (pc_incr),
    .pc         (pc)
  );

  assign rom_address     = pc;
  assign rom_read_enable = (state == ST_FETCH);
  assign instr_valid     = (state == ST_ISSUE);
  assign halted          = (state == ST_HALTED);

endmodule
